raminfr_dp: RTL and testbench



---
 rtl/raminfr_dp.sv | 75 +++++++
 tb/tb_raminfr_dp.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/raminfr_dp.sv
// raminfr_dp: 32x4 true dual-port synchronous RAM, one clock, write-first on
// both ports, port A wins on a same-address write collision. Async reset
// clears the array and both read registers.
module raminfr_dp #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dia,
  output logic [DATA_W-1:0] doa,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dib,
  output logic [DATA_W-1:0] dob
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] doa_q, doa_d;
  logic [DATA_W-1:0] dob_q, dob_d;
  logic              same_addr_c;
  logic              web_commit_c;

  assign same_addr_c  = (addra == addrb);
  // Port B's write is dropped when port A writes the same word
  assign web_commit_c = web && !(wea && same_addr_c);

  // Next read data: own write first, then the other port's write, then memory
  always_comb begin
    doa_d = mem_q[addra];
    dob_d = mem_q[addrb];
    if (wea) begin
      doa_d = dia;
    end else if (web && same_addr_c) begin
      doa_d = dib;
    end
    if (wea && same_addr_c) begin
      dob_d = dia;
    end else if (web) begin
      dob_d = dib;
    end
  end

  // Storage array: cleared on reset, both ports commit on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      if (wea) begin
        mem_q[addra] <= dia;
      end
      if (web_commit_c) begin
        mem_q[addrb] <= dib;
      end
    end
  end

  // Registered read outputs, updated every edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doa_q <= '0;
      dob_q <= '0;
    end else begin
      doa_q <= doa_d;
      dob_q <= dob_d;
    end
  end

  assign doa = doa_q;
  assign dob = dob_q;

endmodule

// File: tb/tb_raminfr_dp.sv
// Directed self-checking bench for raminfr_dp.
module tb_raminfr_dp;

  logic       clk;
  logic       rst_n;
  logic       wea;
  logic [4:0] addra;
  logic [3:0] dia;
  logic [3:0] doa;
  logic       web;
  logic [4:0] addrb;
  logic [3:0] dib;
  logic [3:0] dob;

  int checks;
  int errors;

  raminfr_dp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wea   (wea),
    .addra (addra),
    .dia   (dia),
    .doa   (doa),
    .web   (web),
    .addrb (addrb),
    .dib   (dib),
    .dob   (dob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive both ports, then advance one rising edge and settle 1ns past it
  task automatic drive_step(input logic wa, input logic [4:0] aa, input logic [3:0] da,
                            input logic wb, input logic [4:0] ab, input logic [3:0] db);
    wea = wa; addra = aa; dia = da;
    web = wb; addrb = ab; dib = db;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Make outputs nonzero so the async clear is visible
    drive_step(1'b1, 5'd6, 4'h3, 1'b1, 5'd7, 4'h4);
    checks++;
    if (doa !== 4'h3 || dob !== 4'h4) begin
      errors++;
      $display("FAIL pre_reset_write doa=%h dob=%h expected 3 4", doa, dob);
    end
    // Mid-cycle reset assertion with a write pending
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (doa !== 4'h0 || dob !== 4'h0) begin
      errors++;
      $display("FAIL async_reset_outputs doa=%h dob=%h expected 0 0", doa, dob);
    end
    @(posedge clk);
    #1;
    checks++;
    if (doa !== 4'h0 || dob !== 4'h0) begin
      errors++;
      $display("FAIL reset_held doa=%h dob=%h expected 0 0", doa, dob);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_step(1'b0, 5'd6, 4'hF, 1'b0, 5'd7, 4'hF);
    checks++;
    if (doa !== 4'h0 || dob !== 4'h0) begin
      errors++;
      $display("FAIL reset_cleared_6_7 doa=%h dob=%h expected 0 0", doa, dob);
    end
  endtask

  task automatic test_dual_write();
    drive_step(1'b1, 5'd6, 4'hA, 1'b1, 5'd7, 4'hB);
    checks++;
    if (doa !== 4'hA || dob !== 4'hB) begin
      errors++;
      $display("FAIL dual_write_first doa=%h dob=%h expected a b", doa, dob);
    end
    drive_step(1'b0, 5'd6, 4'h0, 1'b0, 5'd7, 4'h0);
    checks++;
    if (doa !== 4'hA || dob !== 4'hB) begin
      errors++;
      $display("FAIL dual_write_persist doa=%h dob=%h expected a b", doa, dob);
    end
  endtask

  task automatic test_cross_read();
    drive_step(1'b0, 5'd7, 4'h0, 1'b0, 5'd6, 4'h0);
    checks++;
    if (doa !== 4'hB || dob !== 4'hA) begin
      errors++;
      $display("FAIL cross_read doa=%h dob=%h expected b a", doa, dob);
    end
  endtask

  task automatic test_collision();
    drive_step(1'b1, 5'd3, 4'h5, 1'b1, 5'd3, 4'h9);
    checks++;
    if (doa !== 4'h5 || dob !== 4'h5) begin
      errors++;
      $display("FAIL collision_outputs doa=%h dob=%h expected 5 5", doa, dob);
    end
    drive_step(1'b0, 5'd0, 4'h0, 1'b0, 5'd0, 4'h0);
    drive_step(1'b0, 5'd3, 4'h0, 1'b0, 5'd3, 4'h0);
    checks++;
    if (doa !== 4'h5 || dob !== 4'h5) begin
      errors++;
      $display("FAIL collision_stored doa=%h dob=%h expected 5 5", doa, dob);
    end
  endtask

  task automatic test_forward();
    // A writes, B reads same word
    drive_step(1'b1, 5'd10, 4'hC, 1'b0, 5'd10, 4'h7);
    checks++;
    if (doa !== 4'hC || dob !== 4'hC) begin
      errors++;
      $display("FAIL forward_a_to_b doa=%h dob=%h expected c c", doa, dob);
    end
    // B writes, A reads same word
    drive_step(1'b0, 5'd11, 4'h2, 1'b1, 5'd11, 4'hD);
    checks++;
    if (doa !== 4'hD || dob !== 4'hD) begin
      errors++;
      $display("FAIL forward_b_to_a doa=%h dob=%h expected d d", doa, dob);
    end
    drive_step(1'b0, 5'd10, 4'h0, 1'b0, 5'd11, 4'h0);
    checks++;
    if (doa !== 4'hC || dob !== 4'hD) begin
      errors++;
      $display("FAIL forward_stored doa=%h dob=%h expected c d", doa, dob);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    for (int i = 0; i < 32; i++) begin
      exp_a = 4'(i);
      exp_b = 4'(i - 1);
      drive_step(1'b1, 5'(i), 4'(i), 1'b0, 5'(i - 1), 4'h0);
      checks++;
      if (doa !== exp_a) begin
        errors++;
        $display("FAIL sweep_write_a i=%0d doa=%h expected %h", i, doa, exp_a);
      end
      if (i > 0) begin
        checks++;
        if (dob !== exp_b) begin
          errors++;
          $display("FAIL sweep_read_b i=%0d dob=%h expected %h", i, dob, exp_b);
        end
      end
    end
    // Full readback: A ascending, B descending
    for (int i = 0; i < 32; i++) begin
      exp_a = 4'(i);
      exp_b = 4'(31 - i);
      drive_step(1'b0, 5'(i), 4'h0, 1'b0, 5'(31 - i), 4'h0);
      checks++;
      if (doa !== exp_a || dob !== exp_b) begin
        errors++;
        $display("FAIL sweep_readback i=%0d doa=%h dob=%h expected %h %h", i, doa, dob, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [3:0] wv;
    for (int i = 0; i < 16; i++) begin
      wv = ~4'(i);
      drive_step(1'b1, 5'(i), wv, 1'b1, 5'(i + 16), wv);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (doa !== 4'h0 || dob !== 4'h0) begin
      errors++;
      $display("FAIL sweep_async_reset doa=%h dob=%h expected 0 0", doa, dob);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive_step(1'b0, 5'(i), 4'h0, 1'b0, 5'(31 - i), 4'h0);
      checks++;
      if (doa !== 4'h0 || dob !== 4'h0) begin
        errors++;
        $display("FAIL post_reset_zero i=%0d doa=%h dob=%h expected 0 0", i, doa, dob);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    wea = 1'b0; addra = '0; dia = '0;
    web = 1'b0; addrb = '0; dib = '0;
    #1;
    checks++;
    if (doa !== 4'h0 || dob !== 4'h0) begin
      errors++;
      $display("FAIL initial_reset doa=%h dob=%h expected 0 0", doa, dob);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_dual_write();
    test_cross_read();
    test_collision();
    test_forward();
    test_sweep();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
